// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters.
// Optional BUSY watchdog enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_req,
  input  logic [DATA_WIDTH-1:0]      inst_addr,
  output logic                       inst_valid,
  output logic [DATA_WIDTH-1:0]      inst_data,
  input  logic                       data_req,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [BYTE_DATA_WIDTH-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       arb_error
);

  // Handshake: a requester holds req and its fields until its one-cycle valid;
  // the memory sees a level mem_req held stable until a one-cycle mem_valid.
  state_e                     state_q, state_d;
  grant_e                     last_q, last_d;
  grant_e                     gnt_q, gnt_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [BYTE_DATA_WIDTH-1:0] mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0]      inst_data_q, inst_data_d;
  logic                       data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       arb_error_q, arb_error_d;
  logic [DATA_WIDTH-1:0]      resp_data;
  logic                       timeout_hit;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts BUSY cycles; starts at zero in the first BUSY cycle.
  assign cnt_d       = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
  assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_valid_d = 1'b0;
    inst_data_d  = inst_data_q;
    data_valid_d = 1'b0;
    rdata_d      = rdata_q;
    arb_error_d  = 1'b0;
    resp_data    = mem_rdata;
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          if (inst_req && (!data_req || last_q == GNT_DATA)) begin
            gnt_d       = GNT_INST;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = inst_addr;
            mem_wdata_d = '0;
          end else begin
            gnt_d       = GNT_DATA;
            mem_we_d    = data_we;
            mem_be_d    = byte_enable;
            mem_addr_d  = data_addr;
            mem_wdata_d = wdata;
          end
          last_d    = gnt_d;
          mem_req_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A real completion on the watchdog edge takes priority over the timeout.
        if (mem_valid || timeout_hit) begin
          if (!mem_valid) resp_data = DATA_WIDTH'(TIMEOUT_DATA);
          mem_req_d   = 1'b0;
          arb_error_d = !mem_valid;
          if (gnt_q == GNT_INST) begin
            inst_valid_d = 1'b1;
            inst_data_d  = resp_data;
          end else begin
            data_valid_d = 1'b1;
            rdata_d      = resp_data;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= GNT_DATA;
      gnt_q        <= GNT_DATA;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      data_valid_q <= 1'b0;
      rdata_q      <= '0;
      arb_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      data_valid_q <= data_valid_d;
      rdata_q      <= rdata_d;
      arb_error_q  <= arb_error_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign data_valid = data_valid_q;
  assign rdata      = rdata_q;
  assign arb_error  = arb_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences,
// randomized traffic against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int EW = DW + 2;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 256;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int STALL = TMO_EN ? 7 : 20;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req, data_we, mem_valid;
  logic [DW-1:0] inst_addr, data_addr, wdata, mem_rdata;
  logic [BW-1:0] byte_enable;
  logic          inst_valid, data_valid, mem_req, mem_we, arb_error;
  logic [DW-1:0] inst_data, rdata, mem_addr, mem_wdata;
  logic [BW-1:0] mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .BYTE_DATA_WIDTH(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_data(inst_data),
    .data_req(data_req), .data_we(data_we), .byte_enable(byte_enable), .data_addr(data_addr),
    .wdata(wdata), .data_valid(data_valid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .arb_error(arb_error)
  );

  // ---------------- scoreboard / reference model state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q[$];          // {err, side(1=data), data}
  logic [DW-1:0] mem_m[logic [DW-1:0]];
  bit            busy_m, fired, idle_prev, mem_silent, ovr_en;
  bit            v_inst_now, v_data_now;
  grant_e        last_m, win_m;
  int            cnt, mem_delay;
  logic [DW-1:0] ovr_data, m_inst_data, m_rdata, lat_addr, lat_wdata;
  logic          lat_we;
  logic [BW-1:0] lat_be;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_model(input logic [DW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    busy_m = 0; fired = 0; idle_prev = 1; cnt = 0;
    last_m = GNT_DATA;
    m_inst_data = '0; m_rdata = '0;
    mem_valid = 1'b0;
  endtask

  // One cycle: observe outputs at the falling edge, update model, drive memory side.
  task automatic tick();
    logic [EW-1:0] e;
    logic [DW-1:0] resp, old;
    bit vi, vd, gnt_exp;
    @(negedge clk);
    vi = inst_valid; vd = data_valid;
    v_inst_now = vi; v_data_now = vd;
    if (!rst) begin
      model_reset();
      return;
    end
    mem_valid = 1'b0;
    mem_rdata = $urandom();
    if (vi || vd) begin
      check("one_valid_only", DW'(vi & vd), '0);
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_valid: got inst_valid=%0b data_valid=%0b, want none", vi, vd);
      end else begin
        e = exp_q.pop_front();
        check("resp_side", DW'(vd), DW'(e[DW]));
        check("resp_data", vd ? rdata : inst_data, e[DW-1:0]);
        check("resp_err", DW'(arb_error), DW'(e[DW+1]));
        if (vd) m_rdata = e[DW-1:0];
        else    m_inst_data = e[DW-1:0];
      end
      check("resp_mem_req_low", DW'(mem_req), '0);
      busy_m = 0;
    end else begin
      check("arb_error_quiet", DW'(arb_error), '0);
    end
    check("inst_data_hold", inst_data, m_inst_data);
    check("rdata_hold", rdata, m_rdata);
    if (!busy_m && !(vi || vd)) begin
      gnt_exp = idle_prev && (inst_req || data_req);
      check("grant", DW'(mem_req), DW'(gnt_exp));
      if (gnt_exp) begin
        if (inst_req && data_req) win_m = (last_m == GNT_INST) ? GNT_DATA : GNT_INST;
        else                      win_m = inst_req ? GNT_INST : GNT_DATA;
        last_m = win_m;
        busy_m = 1; fired = 0; cnt = 0;
        if (win_m == GNT_INST) begin
          lat_we = 1'b0; lat_be = '1; lat_addr = inst_addr; lat_wdata = '0;
        end else begin
          lat_we = data_we; lat_be = byte_enable; lat_addr = data_addr; lat_wdata = wdata;
        end
      end
    end
    if (busy_m) begin
      check("busy_mem_req", DW'(mem_req), 32'd1);
      check("busy_mem_we", DW'(mem_we), DW'(lat_we));
      check("busy_mem_be", DW'(mem_be), DW'(lat_be));
      check("busy_mem_addr", mem_addr, lat_addr);
      check("busy_mem_wdata", mem_wdata, lat_wdata);
      if (!fired) begin
        cnt++;
        if (!mem_silent && cnt >= mem_delay) begin
          if (lat_we) begin
            old = rd_model(lat_addr);
            for (int b = 0; b < BW; b++) if (lat_be[b]) old[8*b +: 8] = lat_wdata[8*b +: 8];
            mem_m[lat_addr] = old;
            resp = $urandom();
          end else begin
            resp = rd_model(lat_addr);
          end
          if (ovr_en) resp = ovr_data;
          mem_valid = 1'b1;
          mem_rdata = resp;
          fired = 1;
          exp_q.push_back({1'b0, win_m == GNT_DATA, resp});
        end else if (TMO_EN && cnt == TMO) begin
          fired = 1;
          exp_q.push_back({1'b1, win_m == GNT_DATA, TIMEOUT_DATA});
        end
      end
    end
    idle_prev = !busy_m && !(vi || vd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    inst_req = 0; data_req = 0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  typedef struct {
    bit            side;
    bit            we;
    logic [BW-1:0] be;
    logic [DW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] mdata;
    int            delay;
    logic          exp_we;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_data;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit got_g, got_v;
    got_g = 0; got_v = 0;
    mem_delay = v.delay; ovr_en = 1; ovr_data = v.mdata;
    if (v.side) begin
      data_req = 1; data_we = v.we; byte_enable = v.be; data_addr = v.addr; wdata = v.wd;
    end else begin
      inst_req = 1; inst_addr = v.addr;
    end
    for (int c = 0; c < 60 && !got_v; c++) begin
      tick();
      if (!got_g && mem_req) begin
        got_g = 1;
        check("vec_mem_we", DW'(mem_we), DW'(v.exp_we));
        check("vec_mem_be", DW'(mem_be), DW'(v.exp_be));
        check("vec_mem_addr", mem_addr, v.addr);
        check("vec_mem_wdata", mem_wdata, v.exp_wdata);
      end
      if (v_inst_now || v_data_now) begin
        got_v = 1;
        check("vec_side_inst", DW'(v_inst_now), DW'(!v.side));
        check("vec_side_data", DW'(v_data_now), DW'(v.side));
        check("vec_data", v.side ? rdata : inst_data, v.exp_data);
      end
    end
    check("vec_completed", DW'(got_v), 32'd1);
    inst_req = 0; data_req = 0; ovr_en = 0;
    tick();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    int nv, order_i, gstep, vstep;
    bit sides[$];
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_0013, 2, 1'b0, 4'hF, 32'h0, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 1, 1'b1, 4'h3, 32'hCAFE_F00D, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h1234_5678, 32'hA5A5_0001, 3, 1'b0, 4'h0, 32'h1234_5678, 32'hA5A5_0001};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 1, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_0008, 32'h1122_3344, 32'h0BAD_F00D, 5, 1'b1, 4'h8, 32'h1122_3344, 32'h0BAD_F00D};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h0000_0000, 4, 1'b0, 4'hF, 32'h0, 32'h0000_0000};

    inst_req = 0; data_req = 0; data_we = 0; byte_enable = '0;
    inst_addr = '0; data_addr = '0; wdata = '0; mem_rdata = '0;
    mem_silent = 0; ovr_en = 0; ovr_data = '0; mem_delay = 2;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mem_req", DW'(mem_req), '0);
    check("rst_mem_we", DW'(mem_we), '0);
    check("rst_mem_be", DW'(mem_be), '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_inst_valid", DW'(inst_valid), '0);
    check("rst_inst_data", inst_data, '0);
    check("rst_data_valid", DW'(data_valid), '0);
    check("rst_rdata", rdata, '0);
    check("rst_arb_error", DW'(arb_error), '0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests from reset: strict alternation starting with fetch.
    do_reset();
    mem_delay = 2;
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_we = 0; byte_enable = 4'hF; data_addr = 32'h0000_2000; wdata = '0;
    sides.delete();
    for (int c = 0; c < 100 && sides.size() < 4; c++) begin
      tick();
      if (v_inst_now || v_data_now) sides.push_back(v_data_now);
    end
    inst_req = 0; data_req = 0;
    tick();
    check("simul_count", DW'(sides.size()), 32'd4);
    order_i = 0;
    foreach (sides[k]) begin
      check($sformatf("simul_order_%0d", order_i), DW'(sides[k]), DW'(k % 2));
      order_i++;
    end

    // Long stall with the data address changing under a live grant.
    mem_delay = STALL;
    data_req = 1; data_we = 0; data_addr = 32'h0000_0300;
    tick();
    check("stall_grant", DW'(mem_req), 32'd1);
    data_addr = 32'h0000_0999;
    for (int c = 0; c < 60 && !(v_inst_now || v_data_now); c++) begin
      tick();
      if (mem_req) check("stall_mem_addr", mem_addr, 32'h0000_0300);
    end
    check("stall_completed", DW'(v_data_now), 32'd1);
    data_req = 0;
    tick();

    // Stray mem_valid in IDLE, then in RESP: neither may produce a response.
    mem_valid = 1'b1;
    nv = 0;
    repeat (4) begin tick(); if (v_inst_now || v_data_now) nv++; end
    check("stray_idle_no_valid", DW'(nv), '0);
    mem_delay = 1;
    inst_req = 1; inst_addr = 32'h0000_0044;
    for (int c = 0; c < 30 && !v_inst_now; c++) tick();
    inst_req = 0;
    mem_valid = 1'b1;
    nv = 0;
    repeat (4) begin tick(); if (v_inst_now || v_data_now) nv++; end
    check("stray_resp_no_valid", DW'(nv), '0);

    // Reset asserted between edges in the middle of BUSY.
    mem_delay = 10;
    inst_req = 1; inst_addr = 32'h0000_0500;
    for (int c = 0; c < 10 && !mem_req; c++) tick();
    repeat (2) tick();
    #2 rst = 1'b0;
    #1 check("rst_async_mem_req", DW'(mem_req), '0);
    inst_req = 0;
    repeat (2) tick();
    rst = 1'b1;
    nv = 0;
    repeat (6) begin tick(); if (v_inst_now || v_data_now) nv++; end
    check("post_reset_no_valid", DW'(nv), '0);
    mem_delay = 2;
    data_req = 1; data_we = 0; data_addr = 32'h0000_0600;
    tick();
    check("post_reset_grant", DW'(mem_req), 32'd1);
    for (int c = 0; c < 30 && !v_data_now; c++) tick();
    data_req = 0;
    tick();

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Memory never answers: watchdog response after TMO BUSY cycles.
    mem_silent = 1;
    inst_req = 1; inst_addr = 32'h0000_0700;
    gstep = -1; vstep = -1;
    for (int c = 0; c < 40 && vstep < 0; c++) begin
      tick();
      if (gstep < 0 && mem_req) gstep = c;
      if (v_inst_now) begin
        vstep = c;
        check("tmo_inst_data", inst_data, 32'hDEAD_BEEF);
        check("tmo_arb_error", DW'(arb_error), 32'd1);
      end
    end
    inst_req = 0;
    check("tmo_latency", DW'(vstep - gstep), DW'(TMO));
    tick();
    check("tmo_err_one_cycle", DW'(arb_error), '0);
    mem_silent = 0;
    // Completion on the same edge as the watchdog wins.
    mem_delay = TMO;
    data_req = 1; data_we = 0; data_addr = 32'h0000_0704;
    for (int c = 0; c < 40 && !v_data_now; c++) tick();
    check("tmo_tie_no_err", DW'(arb_error), '0);
    check("tmo_tie_data", rdata, rd_model(32'h0000_0704));
    data_req = 0;
    tick();
`endif

    // Randomized traffic from both requesters.
    for (int t = 0; t < 2500; t++) begin
      tick();
      if (!busy_m) mem_delay = $urandom_range(1, 6);
      if (inst_req) begin
        if (v_inst_now) begin
          if ($urandom_range(0, 2) == 0) inst_addr = DW'($urandom_range(0, 15) * 4);
          else inst_req = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        inst_req = 1; inst_addr = DW'($urandom_range(0, 15) * 4);
      end
      if (data_req) begin
        if (v_data_now) begin
          if ($urandom_range(0, 2) == 0) begin
            data_we = $urandom_range(0, 1); byte_enable = BW'($urandom());
            data_addr = DW'($urandom_range(0, 15) * 4); wdata = $urandom();
          end else data_req = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        data_req = 1; data_we = $urandom_range(0, 1); byte_enable = BW'($urandom());
        data_addr = DW'($urandom_range(0, 15) * 4); wdata = $urandom();
      end
    end
    inst_req = 0; data_req = 0;
    repeat (20) tick();
    check("drain_empty", DW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
